// File: rtl/wave_cap_pkg.sv
// wave_cap_pkg
//   Shared definitions for the ADC trigger/capture block:
//   - cap_state_e : capture FSM state encoding (also exported on the debug port)
//   - TRIG_RISE / TRIG_FALL : values of the trig_edge input
//   - clog2 : ceiling log2 used to size counters from parameters
package wave_cap_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PREFILL = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_READY   = 3'd4,
    S_HOLD    = 3'd5
  } cap_state_e;

  localparam logic TRIG_RISE = 1'b0;
  localparam logic TRIG_FALL = 1'b1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_trig_capture_trig_detect.sv
// trig_detect
//   Holds the previous ADC sample and compares it with the current one against
//   the trigger level. o_trig is a single-cycle pulse qualified by i_sample_en;
//   the capture FSM decides whether the pulse matters in its current state.
// Ports
//   sys_clk      in  clock
//   rst          in  asynchronous active-low reset (clears previous sample)
//   i_sample_en  in  sample strobe; previous sample updates on every strobe
//   i_data       in  current ADC sample
//   i_level      in  unsigned trigger threshold
//   i_edge       in  TRIG_RISE / TRIG_FALL
//   o_trig       out crossing detected on this strobe
module trig_detect
  import wave_cap_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              i_sample_en,
  input  logic [DATA_W-1:0] i_data,
  input  logic [DATA_W-1:0] i_level,
  input  logic              i_edge,
  output logic              o_trig
);

  logic [DATA_W-1:0] r_prev;
  logic              w_cross;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_prev <= '0;
    end else if (i_sample_en) begin
      r_prev <= i_data;
    end
  end

  always_comb begin
    w_cross = 1'b0;
    case (i_edge)
      TRIG_RISE: w_cross = (r_prev < i_level) && (i_data >= i_level);
      TRIG_FALL: w_cross = (r_prev > i_level) && (i_data <= i_level);
      default:   w_cross = 1'b0;
    endcase
  end

  assign o_trig = i_sample_en && w_cross;

endmodule

// File: rtl/adc_trig_capture.sv
// adc_trig_capture
//   Capture controller between the ADC front end and the dual-port display RAM.
//   Writes a circular buffer of DEPTH samples around a trigger event (PRE_TRIG
//   samples before it), then holds the frame and reports its oldest address
//   until the display side acknowledges it. A hold-off follows each frame.
//   Optional feature macro: AUTO_TRIG_EN -- forces a trigger after AUTO_TMO
//   strobes in ARMED and flags such frames on auto_flag.
// Ports
//   sys_clk     in  system clock
//   rst         in  asynchronous active-low reset
//   sample_en   in  one-cycle strobe per ADC sample
//   ad_data     in  ADC sample, valid with sample_en
//   trig_level  in  unsigned trigger threshold
//   trig_edge   in  0 = rising, 1 = falling
//   single      in  1 = stop after one frame, 0 = re-arm after hold-off
//   arm         in  start capture from IDLE
//   rd_done     in  display consumed the frame
//   wr_en       out buffer write enable
//   wr_addr     out buffer write address
//   wr_data     out buffer write data
//   frame_ready out complete frame held
//   start_addr  out address of oldest frame sample
//   auto_flag   out current frame was forced by timeout
//   state       out FSM state (debug)
module adc_trig_capture
  import wave_cap_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int DEPTH    = 1024,
  parameter  int PRE_TRIG = 256,
  parameter  int HOLDOFF  = 6000000,
  parameter  int AUTO_TMO = 2000000,
  localparam int ADDR_W   = clog2(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] ad_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic              single,
  input  logic              arm,
  input  logic              rd_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_ready,
  output logic [ADDR_W-1:0] start_addr,
  output logic              auto_flag,
  output logic [2:0]        state
);

  localparam int POST_LEN = DEPTH - PRE_TRIG - 1;
  // HOLDOFF = 0 still spends one cycle in HOLD
  localparam int HOLD_CYC = (HOLDOFF > 0) ? HOLDOFF : 1;
  localparam int HOLD_W   = (clog2(HOLD_CYC) > 0) ? clog2(HOLD_CYC) : 1;

  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  cap_state_e        r_state;
  cap_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;        // next buffer address to write
  logic [ADDR_W-1:0] r_cnt;        // samples written in PREFILL / POST
  logic [HOLD_W-1:0] r_hold;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [ADDR_W-1:0] r_start;
  logic              r_frame_ready;
  logic              w_write;      // current strobe goes into the buffer
  logic              w_fire;       // trigger accepted on current strobe
  logic              w_trig;
  logic              w_force;

  trig_detect #(
    .DATA_W (DATA_W)
  ) u_trig (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .i_sample_en (sample_en),
    .i_data      (ad_data),
    .i_level     (trig_level),
    .i_edge      (trig_edge),
    .o_trig      (w_trig)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_write     = 1'b0;
    w_fire      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (arm) w_state_nxt = (PRE_TRIG > 0) ? S_PREFILL : S_ARMED;
      end
      S_PREFILL: begin
        if (sample_en) begin
          w_write = 1'b1;
          if (r_cnt == PRE_LAST) w_state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (sample_en) begin
          w_write = 1'b1;
          if (w_trig || w_force) begin
            w_fire      = 1'b1;
            w_state_nxt = (POST_LEN == 0) ? S_READY : S_POST;
          end
        end
      end
      S_POST: begin
        if (sample_en) begin
          w_write = 1'b1;
          if (r_cnt == POST_LAST) w_state_nxt = S_READY;
        end
      end
      S_READY: begin
        // a strobe arriving with rd_done is dropped: READY never writes
        if (rd_done) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (r_hold == HOLD_LAST) begin
          if (single) w_state_nxt = S_IDLE;
          else        w_state_nxt = (PRE_TRIG > 0) ? S_PREFILL : S_ARMED;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---- register stage: state, write port, frame bookkeeping ----
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_hold        <= '0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_start       <= '0;
      r_frame_ready <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wr_en       <= w_write;
      r_frame_ready <= (w_state_nxt == S_READY);
      if (w_write) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= ad_data;
        r_ptr     <= r_ptr + ADDR_ONE;
      end
      // the trigger sample sits at r_ptr; the frame begins PRE_TRIG earlier
      if (w_fire) r_start <= r_ptr - PRE_OFS;
      // phase sample count restarts on every state change
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (w_write)           r_cnt <= r_cnt + ADDR_ONE;
      if (r_state == S_HOLD) r_hold <= r_hold + HOLD_ONE;
      else                   r_hold <= '0;
    end
  end

`ifdef AUTO_TRIG_EN
  localparam int TMO_CYC = (AUTO_TMO > 0) ? AUTO_TMO : 1;
  localparam int TMO_W   = (clog2(TMO_CYC) > 0) ? clog2(TMO_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  logic [TMO_W-1:0] r_tmo;
  logic             r_auto;
  logic             w_arming;

  assign w_force  = (r_state == S_ARMED) && sample_en && (r_tmo == TMO_LAST);
  assign w_arming = ((r_state == S_IDLE) || (r_state == S_HOLD)) &&
                    ((w_state_nxt == S_PREFILL) || (w_state_nxt == S_ARMED));

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_tmo  <= '0;
      r_auto <= 1'b0;
    end else begin
      // held at zero outside ARMED, so every ARMED entry starts a fresh count
      if (r_state != S_ARMED) r_tmo <= '0;
      else if (sample_en)     r_tmo <= r_tmo + TMO_ONE;
      if (w_arming)    r_auto <= 1'b0;
      else if (w_fire) r_auto <= !w_trig;
    end
  end

  assign auto_flag = r_auto;
`else
  assign w_force   = 1'b0;
  // timeout is compiled out; this is constant 0 for any legal AUTO_TMO
  assign auto_flag = (AUTO_TMO < 0);
`endif

  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign frame_ready = r_frame_ready;
  assign start_addr  = r_start;
  assign state       = r_state;

endmodule

// File: tb/tb_adc_trig_capture.sv
// tb_adc_trig_capture
//   Directed bench for adc_trig_capture with DEPTH=16, PRE_TRIG=4, HOLDOFF=10,
//   AUTO_TMO=32 and one sample strobe every 4 clocks. A small RAM model
//   records every write so frames can be read back from start_addr.
module tb_adc_trig_capture;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PREFILL = 3'd1;
  localparam logic [2:0] ST_ARMED   = 3'd2;
  localparam logic [2:0] ST_POST    = 3'd3;
  localparam logic [2:0] ST_READY   = 3'd4;
  localparam logic [2:0] ST_HOLD    = 3'd5;

  logic       sys_clk    = 1'b0;
  logic       rst        = 1'b0;
  logic       sample_en  = 1'b0;
  logic [7:0] ad_data    = 8'd0;
  logic [7:0] trig_level = 8'd0;
  logic       trig_edge  = 1'b0;
  logic       single     = 1'b1;
  logic       arm        = 1'b0;
  logic       rd_done    = 1'b0;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_ready;
  logic [3:0] start_addr;
  logic       auto_flag;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [16];
  int         wr_count = 0;

  always #5 sys_clk = ~sys_clk;

  adc_trig_capture #(
    .DATA_W   (8),
    .DEPTH    (16),
    .PRE_TRIG (4),
    .HOLDOFF  (10),
    .AUTO_TMO (32)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .sample_en   (sample_en),
    .ad_data     (ad_data),
    .trig_level  (trig_level),
    .trig_edge   (trig_edge),
    .single      (single),
    .arm         (arm),
    .rd_done     (rd_done),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_ready (frame_ready),
    .start_addr  (start_addr),
    .auto_flag   (auto_flag),
    .state       (state)
  );

  // display RAM model
  always @(negedge sys_clk) begin
    if (wr_en === 1'b1) begin
      mem[wr_addr] = wr_data;
      wr_count     = wr_count + 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send_sample(input logic [7:0] v);
    cyc(3);
    ad_data   = v;
    sample_en = 1'b1;
    cyc(1);
    sample_en = 1'b0;
  endtask

  task automatic ramp_samples(input int first, input int n);
    for (int i = 0; i < n; i++) send_sample(8'((first + i) * 8));
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    cyc(1);
    arm = 1'b0;
  endtask

  task automatic pulse_rd_done();
    rd_done = 1'b1;
    cyc(1);
    rd_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cyc(2);
    n_checks++;
    if ({wr_en, wr_addr, wr_data, frame_ready, start_addr, auto_flag, state} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {wr_en, wr_addr, wr_data, frame_ready, start_addr, auto_flag, state});
    end
    rst = 1'b1;
    cyc(1);
    n_checks++;
    if (state !== ST_IDLE) begin n_fail++; $display("FAIL reset_idle: got %0d required %0d", state, ST_IDLE); end
  endtask

  task automatic test_rising_ramp();
    int base;
    base = wr_count;
    trig_level = 8'd100; trig_edge = 1'b0; single = 1'b1;
    pulse_arm();
    n_checks++;
    if (state !== ST_PREFILL) begin n_fail++; $display("FAIL ramp_prefill: got %0d required %0d", state, ST_PREFILL); end
    ramp_samples(0, 4);
    n_checks++;
    if (state !== ST_ARMED) begin n_fail++; $display("FAIL ramp_armed: got %0d required %0d", state, ST_ARMED); end
    ramp_samples(4, 9);
    n_checks++;
    if (state !== ST_ARMED) begin n_fail++; $display("FAIL ramp_before_trig: got %0d required %0d", state, ST_ARMED); end
    ramp_samples(13, 1);
    n_checks++;
    if (state !== ST_POST) begin n_fail++; $display("FAIL ramp_post: got %0d required %0d", state, ST_POST); end
    n_checks++;
    if (start_addr !== 4'd9) begin n_fail++; $display("FAIL ramp_start: got %0d required 9", start_addr); end
    ramp_samples(14, 10);
    n_checks++;
    if (state !== ST_POST) begin n_fail++; $display("FAIL ramp_post_len: got %0d required %0d", state, ST_POST); end
    ramp_samples(24, 1);
    n_checks++;
    if (state !== ST_READY || frame_ready !== 1'b1) begin
      n_fail++; $display("FAIL ramp_ready: got state %0d ready %0b required %0d 1", state, frame_ready, ST_READY);
    end
    cyc(2);
    n_checks++;
    if (wr_count - base !== 25) begin n_fail++; $display("FAIL ramp_writes: got %0d required 25", wr_count - base); end
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (mem[(9 + k) % 16] !== 8'((9 + k) * 8)) begin
        n_fail++; $display("FAIL ramp_frame[%0d]: got %0d required %0d", k, mem[(9 + k) % 16], (9 + k) * 8);
      end
    end
    send_sample(8'd0);
    cyc(2);
    n_checks++;
    if (wr_count - base !== 25 || frame_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_no_write: got writes %0d ready %0b required 25 1", wr_count - base, frame_ready);
    end
  endtask

  task automatic test_single_hold();
    int base;
    base = wr_count;
    single = 1'b1;
    ad_data = 8'd0; sample_en = 1'b1; rd_done = 1'b1;
    cyc(1);
    sample_en = 1'b0; rd_done = 1'b0;
    n_checks++;
    if (state !== ST_HOLD || frame_ready !== 1'b0) begin
      n_fail++; $display("FAIL hold_enter: got state %0d ready %0b required %0d 0", state, frame_ready, ST_HOLD);
    end
    cyc(9);
    n_checks++;
    if (state !== ST_HOLD) begin n_fail++; $display("FAIL hold_len: got %0d required %0d", state, ST_HOLD); end
    cyc(1);
    n_checks++;
    if (state !== ST_IDLE) begin n_fail++; $display("FAIL hold_to_idle: got %0d required %0d", state, ST_IDLE); end
    send_sample(8'd0);
    send_sample(8'd0);
    pulse_rd_done();
    cyc(2);
    n_checks++;
    if (wr_count !== base) begin n_fail++; $display("FAIL idle_no_write: got %0d writes required 0", wr_count - base); end
    n_checks++;
    if (state !== ST_IDLE) begin n_fail++; $display("FAIL idle_rd_done: got %0d required %0d", state, ST_IDLE); end
  endtask

  task automatic test_falling_triangle();
    logic [7:0] head [5];
    logic [7:0] exp_v;
    head = '{8'd80, 8'd100, 8'd80, 8'd60, 8'd40};
    trig_level = 8'd50; trig_edge = 1'b1;
    pulse_arm();
    send_sample(8'd10); send_sample(8'd20); send_sample(8'd30); send_sample(8'd40);
    send_sample(8'd60);
    n_checks++;
    if (state !== ST_ARMED) begin n_fail++; $display("FAIL fall_up_cross: got %0d required %0d", state, ST_ARMED); end
    send_sample(8'd80); send_sample(8'd100); send_sample(8'd80); send_sample(8'd60);
    n_checks++;
    if (state !== ST_ARMED) begin n_fail++; $display("FAIL fall_above: got %0d required %0d", state, ST_ARMED); end
    send_sample(8'd40);
    n_checks++;
    if (state !== ST_POST) begin n_fail++; $display("FAIL fall_trig: got %0d required %0d", state, ST_POST); end
    n_checks++;
    if (start_addr !== 4'd14) begin n_fail++; $display("FAIL fall_start: got %0d required 14", start_addr); end
    for (int i = 0; i < 11; i++) send_sample(8'(201 + i));
    n_checks++;
    if (state !== ST_READY) begin n_fail++; $display("FAIL fall_ready: got %0d required %0d", state, ST_READY); end
    cyc(2);
    for (int k = 0; k < 16; k++) begin
      exp_v = (k < 5) ? head[k] : 8'(201 + k - 5);
      n_checks++;
      if (mem[(14 + k) % 16] !== exp_v) begin
        n_fail++; $display("FAIL fall_frame[%0d]: got %0d required %0d", k, mem[(14 + k) % 16], exp_v);
      end
    end
  endtask

  task automatic test_repeat_prefill();
    single = 1'b0;
    pulse_rd_done();
    cyc(9);
    n_checks++;
    if (state !== ST_HOLD) begin n_fail++; $display("FAIL rep_hold: got %0d required %0d", state, ST_HOLD); end
    cyc(1);
    n_checks++;
    if (state !== ST_PREFILL) begin n_fail++; $display("FAIL rep_rearm: got %0d required %0d", state, ST_PREFILL); end
    trig_level = 8'd100; trig_edge = 1'b0;
    send_sample(8'd0);
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 4'd14) begin
      n_fail++; $display("FAIL rep_addr: got en %0b addr %0d required 1 14", wr_en, wr_addr);
    end
    send_sample(8'd150);
    n_checks++;
    if (state !== ST_PREFILL) begin n_fail++; $display("FAIL prefill_cross: got %0d required %0d", state, ST_PREFILL); end
    send_sample(8'd0); send_sample(8'd50);
    n_checks++;
    if (state !== ST_ARMED) begin n_fail++; $display("FAIL rep_armed: got %0d required %0d", state, ST_ARMED); end
    send_sample(8'd120);
    n_checks++;
    if (state !== ST_POST || start_addr !== 4'd14) begin
      n_fail++; $display("FAIL rep_trig: got state %0d start %0d required %0d 14", state, start_addr, ST_POST);
    end
    for (int i = 1; i <= 11; i++) send_sample(8'(i));
    n_checks++;
    if (state !== ST_READY || frame_ready !== 1'b1) begin
      n_fail++; $display("FAIL rep_ready: got state %0d ready %0b required %0d 1", state, frame_ready, ST_READY);
    end
    cyc(2);
    n_checks++;
    if (mem[15] !== 8'd150 || mem[2] !== 8'd120 || mem[13] !== 8'd11) begin
      n_fail++; $display("FAIL rep_frame: got %0d %0d %0d required 150 120 11", mem[15], mem[2], mem[13]);
    end
  endtask

  task automatic test_rst_mid_post();
    single = 1'b1;
    rst = 1'b0; cyc(2); rst = 1'b1; cyc(1);
    pulse_arm();
    ramp_samples(0, 17);
    n_checks++;
    if (state !== ST_POST) begin n_fail++; $display("FAIL rst_setup: got %0d required %0d", state, ST_POST); end
    cyc(1);
    rst = 1'b0;
    cyc(1);
    n_checks++;
    if ({wr_en, wr_addr, wr_data, frame_ready, start_addr, auto_flag, state} !== 22'd0) begin
      n_fail++;
      $display("FAIL rst_mid_post: got %h required 0", {wr_en, wr_addr, wr_data, frame_ready, start_addr, auto_flag, state});
    end
    rst = 1'b1;
    cyc(1);
    pulse_arm();
    ramp_samples(0, 25);
    n_checks++;
    if (state !== ST_READY || start_addr !== 4'd9) begin
      n_fail++; $display("FAIL rst_refresh: got state %0d start %0d required %0d 9", state, start_addr, ST_READY);
    end
    cyc(2);
    for (int k = 0; k < 16; k += 5) begin
      n_checks++;
      if (mem[(9 + k) % 16] !== 8'((9 + k) * 8)) begin
        n_fail++; $display("FAIL rst_frame[%0d]: got %0d required %0d", k, mem[(9 + k) % 16], (9 + k) * 8);
      end
    end
  endtask

  task automatic test_auto_timeout();
    rst = 1'b0; cyc(2); rst = 1'b1; cyc(1);
    single = 1'b1; trig_level = 8'd100; trig_edge = 1'b0;
    pulse_arm();
    for (int i = 0; i < 4; i++) send_sample(8'd200);
    n_checks++;
    if (state !== ST_ARMED) begin n_fail++; $display("FAIL dc_prefill: got %0d required %0d", state, ST_ARMED); end
    for (int i = 0; i < 31; i++) send_sample(8'd200);
    pulse_rd_done();
    n_checks++;
    if (state !== ST_ARMED || auto_flag !== 1'b0) begin
      n_fail++; $display("FAIL dc_wait: got state %0d auto %0b required %0d 0", state, auto_flag, ST_ARMED);
    end
    send_sample(8'd200);
`ifdef AUTO_TRIG_EN
    n_checks++;
    if (state !== ST_POST || auto_flag !== 1'b1 || start_addr !== 4'd15) begin
      n_fail++; $display("FAIL auto_force: got state %0d auto %0b start %0d required %0d 1 15", state, auto_flag, start_addr, ST_POST);
    end
    for (int i = 0; i < 11; i++) send_sample(8'd200);
    n_checks++;
    if (state !== ST_READY || auto_flag !== 1'b1) begin
      n_fail++; $display("FAIL auto_ready: got state %0d auto %0b required %0d 1", state, auto_flag, ST_READY);
    end
`else
    n_checks++;
    if (state !== ST_ARMED || auto_flag !== 1'b0) begin
      n_fail++; $display("FAIL no_auto: got state %0d auto %0b required %0d 0", state, auto_flag, ST_ARMED);
    end
    for (int i = 0; i < 16; i++) send_sample(8'd200);
    n_checks++;
    if (state !== ST_ARMED) begin n_fail++; $display("FAIL no_auto_long: got %0d required %0d", state, ST_ARMED); end
`endif
  endtask

  initial begin
    test_reset();
    test_rising_ramp();
    test_single_hold();
    test_falling_triangle();
    test_repeat_prefill();
    test_rst_mid_post();
    test_auto_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
